// File: rtl/cache_pkg.sv
// Shared geometry, controller state encoding and tree pLRU helpers for nway_cache.
package cache_pkg;

    localparam int s_offset = 5;
    localparam int s_mask   = 32;
    localparam int s_line   = 256;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FILL      = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        WRITEBACK = ST_WRITEBACK,
        FILL      = ST_FILL
    } state_t;

    // Tree depth for a legal associativity (1, 2, 4 or 8 ways).
    function automatic int unsigned plru_levels(input int unsigned n_ways);
        return (n_ways >= 8) ? 3 : (n_ways >= 4) ? 2 : (n_ways >= 2) ? 1 : 0;
    endfunction

    // Walk the heap-ordered tree from the root; a 0 bit steers left, 1 steers right.
    function automatic logic [2:0] plru_victim(input logic [6:0] tree, input int unsigned n_ways);
        logic [2:0] way;
        logic [2:0] node;
        way  = '0;
        node = '0;
        for (int unsigned lvl = 0; lvl < plru_levels(n_ways); lvl++) begin
            way  = {way[1:0], tree[node]};
            node = (node << 1) + 3'd1 + {2'b00, tree[node]};
        end
        return way;
    endfunction

    // Make every node on the path to `way` point to the opposite subtree.
    function automatic logic [6:0] plru_touch(input logic [6:0] tree, input logic [2:0] way,
                                              input int unsigned n_ways);
        logic [6:0] t;
        logic [2:0] node;
        logic [1:0] bit_sel;
        logic       b;
        t    = tree;
        node = '0;
        for (int unsigned lvl = 0; lvl < plru_levels(n_ways); lvl++) begin
            bit_sel = 2'(plru_levels(n_ways) - 1 - lvl);
            b       = way[bit_sel];
            t[node] = ~b;
            node    = (node << 1) + 3'd1 + {2'b00, b};
        end
        return t;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: line data with byte mask, tag, valid and dirty per set.
module cache_way
    import cache_pkg::*;
#(
    parameter int s_index = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [s_index-1:0]            index,
    input  logic [s_mask-1:0]             data_mask,
    input  logic [s_line-1:0]             data_in,
    input  logic                          tag_load,
    input  logic [31-s_offset-s_index:0]  tag_in,
    input  logic                          valid_load,
    input  logic                          valid_in,
    input  logic                          dirty_load,
    input  logic                          dirty_in,
    output logic [s_line-1:0]             data_out,
    output logic [31-s_offset-s_index:0]  tag_out,
    output logic                          valid_out,
    output logic                          dirty_out
);

    localparam int num_sets = 2 ** s_index;

    logic [s_line-1:0]            data  [num_sets];
    logic [31-s_offset-s_index:0] tag   [num_sets];
    logic [num_sets-1:0]          valid;
    logic [num_sets-1:0]          dirty;

    // Status bits are cleared by reset; data and tag keep stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (valid_load) valid[index] <= valid_in;
            if (dirty_load) dirty[index] <= dirty_in;
        end
    end

    // Byte-masked line write and tag load.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < s_mask; b++) begin
            if (data_mask[b]) data[index][8*b +: 8] <= data_in[8*b +: 8];
        end
        if (tag_load) tag[index] <= tag_in;
    end

    assign data_out  = data[index];
    assign tag_out   = tag[index];
    assign valid_out = valid[index];
    assign dirty_out = dirty[index];

endmodule

// File: rtl/nway_cache.sv
// N-way set-associative write-back, write-allocate line cache with pLRU replacement.
module nway_cache
    import cache_pkg::*;
#(
    parameter int          s_index = 3,
    parameter int unsigned ways    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [s_mask-1:0] mem_byte_enable,
    input  logic [s_line-1:0] mem_wdata,
    output logic [s_line-1:0] mem_rdata,
    output logic              mem_resp,
    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int s_tag    = 32 - s_offset - s_index;
    localparam int num_sets = 2 ** s_index;
    localparam int way_w    = (ways > 1) ? $clog2(ways) : 1;

    logic [s_tag-1:0]   tag_req;
    logic [s_index-1:0] idx;
    logic [4:0]         offset_unused;

    logic [s_line-1:0]  way_data [ways];
    logic [s_tag-1:0]   way_tag  [ways];
    logic [ways-1:0]    way_valid, way_dirty;
    logic [s_mask-1:0]  way_mask [ways];
    logic [ways-1:0]    tag_load, valid_load, dirty_load;
    logic [s_line-1:0]  data_in;
    logic               dirty_in;

    state_t             state, state_next;
    logic [way_w-1:0]   victim_q, victim_next, victim_pick, hit_way, first_invalid;
    logic               hit, has_invalid, plru_we;
    logic [6:0]         plru [num_sets];
    logic [6:0]         plru_touched;

    assign tag_req       = mem_address[31:s_offset+s_index];
    assign idx           = mem_address[s_offset+s_index-1:s_offset];
    assign offset_unused = mem_address[4:0];

    for (genvar w = 0; w < ways; w++) begin : g_way
        cache_way #(.s_index(s_index)) u_way (
            .clk        (clk),
            .rst        (rst),
            .index      (idx),
            .data_mask  (way_mask[w]),
            .data_in    (data_in),
            .tag_load   (tag_load[w]),
            .tag_in     (tag_req),
            .valid_load (valid_load[w]),
            .valid_in   (1'b1),
            .dirty_load (dirty_load[w]),
            .dirty_in   (dirty_in),
            .data_out   (way_data[w]),
            .tag_out    (way_tag[w]),
            .valid_out  (way_valid[w]),
            .dirty_out  (way_dirty[w])
        );
    end

    // Tag compare across ways and victim choice (invalid ways before pLRU).
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        has_invalid   = 1'b0;
        first_invalid = '0;
        for (int unsigned w = 0; w < ways; w++) begin
            if (way_valid[w] && (way_tag[w] == tag_req) && !hit) begin
                hit     = 1'b1;
                hit_way = way_w'(w);
            end
            if (!way_valid[w] && !has_invalid) begin
                has_invalid   = 1'b1;
                first_invalid = way_w'(w);
            end
        end
        victim_pick  = has_invalid ? first_invalid : way_w'(plru_victim(plru[idx], ways));
        plru_touched = plru_touch(plru[idx], 3'(hit_way), ways);
    end

    // Controller outputs and array write strobes; reset suppresses every write.
    always_comb begin
        state_next   = state;
        victim_next  = victim_q;
        mem_resp     = 1'b0;
        mem_rdata    = way_data[hit_way];
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = way_data[victim_q];
        data_in      = mem_wdata;
        dirty_in     = 1'b0;
        tag_load     = '0;
        valid_load   = '0;
        dirty_load   = '0;
        plru_we      = 1'b0;
        for (int unsigned w = 0; w < ways; w++) way_mask[w] = '0;

        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        plru_we  = 1'b1;
                        if (mem_write) begin
                            way_mask[hit_way]   = mem_byte_enable;
                            dirty_load[hit_way] = 1'b1;
                            dirty_in            = 1'b1;
                        end
                    end else begin
                        victim_next = victim_pick;
                        state_next  = (way_valid[victim_pick] && way_dirty[victim_pick])
                                      ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {way_tag[victim_q], idx, 5'b0};
                if (pmem_resp) state_next = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {tag_req, idx, 5'b0};
                if (pmem_resp) begin
                    data_in              = pmem_rdata;
                    way_mask[victim_q]   = '1;
                    tag_load[victim_q]   = 1'b1;
                    valid_load[victim_q] = 1'b1;
                    dirty_load[victim_q] = 1'b1;
                    state_next           = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (rst) begin
            mem_resp     = 1'b0;
            pmem_read    = 1'b0;
            pmem_write   = 1'b0;
            pmem_address = '0;
            tag_load     = '0;
            valid_load   = '0;
            dirty_load   = '0;
            plru_we      = 1'b0;
            for (int unsigned w = 0; w < ways; w++) way_mask[w] = '0;
        end
    end

    // State, latched victim and per-set pLRU trees.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            victim_q <= '0;
            for (int unsigned s = 0; s < num_sets; s++) plru[s] <= '0;
        end else begin
            state    <= state_next;
            victim_q <= victim_next;
            if (plru_we) plru[idx] <= plru_touched;
        end
    end

endmodule
